// File: rtl/paramList_pkg.sv
// ============================================================================
// paramList -- shared constants and state encoding for the gain update block
// Rev 1.0
// ============================================================================
`default_nettype none

package paramList;

    localparam logic [11:0] PAST_QUA_EN   = 12'h100;
    localparam logic [15:0] LOG2_EXP_BIAS = 16'd13;
    localparam logic [15:0] LOG2_TO_DB    = 16'd24660;

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        SHIFT_RD = 4'd1,
        SHIFT_WR = 4'd2,
        LOG_REQ  = 4'd3,
        LOG_WAIT = 4'd4,
        COMP_HI  = 4'd5,
        COMP_LO  = 4'd6,
        SHL      = 4'd7,
        WRITE0   = 4'd8,
        FINAL    = 4'd9
    } gain_update_state_t;

    function automatic logic [11:0] past_qua_en_addr(input logic [1:0] k);
        return {PAST_QUA_EN[11:2], k};
    endfunction

endpackage

`default_nettype wire

// File: rtl/gain_update.sv
// ============================================================================
// gain_update -- G.729 MA predictor energy history update via shared operators
// Rev 1.0
// ============================================================================
`default_nettype none

module gain_update
    import paramList::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [31:0] L_gbk12,
    output logic [15:0] sub_a,
    output logic [15:0] sub_b,
    input  logic [15:0] sub_in,
    output logic [31:0] L_add_a,
    output logic [31:0] L_add_b,
    input  logic [31:0] L_add_in,
    output logic [31:0] L_shl_a,
    output logic [15:0] L_shl_b,
    input  logic [31:0] L_shl_in,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    input  logic [15:0] mult_in,
    output logic        log2_start,
    output logic [31:0] log2_in,
    input  logic        log2_done,
    input  logic [15:0] log2_exp,
    input  logic [15:0] log2_frac,
    output logic [11:0] scratch_mem_read_addr,
    output logic [11:0] scratch_mem_write_addr,
    output logic        scratch_mem_write_en,
    output logic [31:0] scratch_mem_out,
    input  logic [31:0] scratch_mem_in
);

    gain_update_state_t r_state, w_state_next;

    logic [1:0]  r_i;
    logic [1:0]  r_k;
    logic [31:0] r_gbk;
    logic [15:0] r_exp;
    logic [15:0] r_frac;
    logic [15:0] r_hi;
    logic [31:0] r_acc;
    logic [15:0] r_tmp;
    logic        r_next_done;

    // Only the high half of the shifted accumulator is kept.
    logic w_unused_shl_lo;
    assign w_unused_shl_lo = ^L_shl_in[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_i         <= 2'd0;
            r_k         <= 2'd0;
            r_gbk       <= 32'd0;
            r_exp       <= 16'd0;
            r_frac      <= 16'd0;
            r_hi        <= 16'd0;
            r_acc       <= 32'd0;
            r_tmp       <= 16'd0;
            r_next_done <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            done        <= r_next_done;
            r_next_done <= 1'b0;
            case (r_state)
                INIT: begin
                    if (start) begin
                        r_gbk <= L_gbk12;
                        r_i   <= 2'd3;
                    end
                end
                SHIFT_RD: r_k <= sub_in[1:0];
                SHIFT_WR: r_i <= r_k;
                LOG_WAIT: begin
                    if (log2_done) begin
                        r_exp  <= log2_exp;
                        r_frac <= log2_frac;
                    end
                end
                COMP_HI:  r_hi        <= sub_in;
                COMP_LO:  r_acc       <= L_add_in;
                SHL:      r_tmp       <= L_shl_in[31:16];
                WRITE0:   r_next_done <= 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_state_next           = r_state;
        sub_a                  = 16'd0;
        sub_b                  = 16'd0;
        L_add_a                = 32'd0;
        L_add_b                = 32'd0;
        L_shl_a                = 32'd0;
        L_shl_b                = 16'd0;
        mult_a                 = 16'd0;
        mult_b                 = 16'd0;
        log2_start             = 1'b0;
        log2_in                = 32'd0;
        scratch_mem_read_addr  = 12'd0;
        scratch_mem_write_addr = 12'd0;
        scratch_mem_write_en   = 1'b0;
        scratch_mem_out        = 32'd0;
        case (r_state)
            INIT: begin
                if (start) w_state_next = SHIFT_RD;
            end
            SHIFT_RD: begin
                sub_a                 = {14'd0, r_i};
                sub_b                 = 16'd1;
                scratch_mem_read_addr = past_qua_en_addr(sub_in[1:0]);
                w_state_next          = SHIFT_WR;
            end
            SHIFT_WR: begin
                // Descending walk: entry i-1 was read before entry i is overwritten.
                scratch_mem_write_addr = past_qua_en_addr(r_i);
                scratch_mem_write_en   = 1'b1;
                scratch_mem_out        = scratch_mem_in;
                w_state_next           = (r_i > 2'd1) ? SHIFT_RD : LOG_REQ;
            end
            LOG_REQ: begin
                log2_start   = 1'b1;
                log2_in      = r_gbk;
                w_state_next = LOG_WAIT;
            end
            LOG_WAIT: begin
                log2_in = r_gbk;
                if (log2_done) w_state_next = COMP_HI;
            end
            COMP_HI: begin
                sub_a        = r_exp;
                sub_b        = LOG2_EXP_BIAS;
                w_state_next = COMP_LO;
            end
            COMP_LO: begin
                L_add_a      = {r_hi, 16'd0};
                L_add_b      = {{15{r_frac[15]}}, r_frac, 1'b0};
                w_state_next = SHL;
            end
            SHL: begin
                L_shl_a      = r_acc;
                L_shl_b      = LOG2_EXP_BIAS;
                w_state_next = WRITE0;
            end
            WRITE0: begin
                mult_a                 = r_tmp;
                mult_b                 = LOG2_TO_DB;
                scratch_mem_write_addr = past_qua_en_addr(2'd0);
                scratch_mem_write_en   = 1'b1;
                scratch_mem_out        = {{16{mult_in[15]}}, mult_in};
                w_state_next           = FINAL;
            end
            FINAL:   w_state_next = INIT;
            default: w_state_next = INIT;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/gain_update.md
GAIN_UPDATE -- requirements
Module: gain_update

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports start (input, 1) and done (output, 1): start launches one update; done is a registered one-cycle completion pulse.
REQ-004 SHALL have port L_gbk12, input, 32: codebook gain product (Q12 energy term), sampled when start is accepted.
REQ-005 SHALL have shared-operator ports sub_a/sub_b (output, 16) and sub_in (input, 16).
REQ-006 SHALL have shared-operator ports L_add_a/L_add_b (output, 32) and L_add_in (input, 32).
REQ-007 SHALL have shared-operator ports L_shl_a (output, 32), L_shl_b (output, 16) and L_shl_in (input, 32).
REQ-008 SHALL have shared-operator ports mult_a/mult_b (output, 16) and mult_in (input, 16).
REQ-009 SHALL have Log2 handshake ports log2_start (output, 1), log2_in (output, 32), log2_done (input, 1), log2_exp (input, 16) and log2_frac (input, 16).
REQ-010 SHALL have scratch memory ports scratch_mem_read_addr and scratch_mem_write_addr (output, 12), scratch_mem_write_en (output, 1), scratch_mem_out (output, 32) and scratch_mem_in (input, 32); read data is valid the cycle after the address is driven.

Function
REQ-011 SHALL implement the G.729 normal-frame predictor update: past_qua_en[3..1] = past_qua_en[2..0]; then past_qua_en[0] = mult(extract_h(L_shl(L_Comp(exp-13, frac), 13)), 24660), where (exp, frac) = Log2(L_gbk12).
REQ-012 SHALL address past_qua_en[k] at {PAST_QUA_EN[11:2], k[1:0]}, each entry a 16-bit value sign-extended to 32 bits on write.
REQ-013 SHALL hold states INIT, SHIFT_RD, SHIFT_WR, LOG_REQ, LOG_WAIT, COMP_HI, COMP_LO, SHL, WRITE0 and FINAL.
REQ-014 INIT: on start, SHALL latch L_gbk12, set loop index i=3 and go to SHIFT_RD; with start low, SHALL stay in INIT.
REQ-015 SHIFT_RD: SHALL drive read address k=i-1 (via sub port) and go to SHIFT_WR; SHIFT_WR SHALL write scratch_mem_in to entry i, decrement i, and return to SHIFT_RD while i>1, else go to LOG_REQ.
REQ-016 Shift order SHALL be descending (3, 2, 1) so no entry is overwritten before it is read.
REQ-017 LOG_REQ: SHALL pulse log2_start for one cycle with log2_in = latched L_gbk12 held stable; LOG_WAIT SHALL wait indefinitely for log2_done and then latch log2_exp and log2_frac.
REQ-018 COMP_HI: SHALL compute hi = sub(exp, 13); COMP_LO SHALL compute L_acc = L_add(hi<<16, frac<<1).
REQ-019 SHL: SHALL compute L_shl(L_acc, 13), saturating, and keep its upper 16 bits as tmp.
REQ-020 WRITE0: SHALL compute mult(tmp, 24660), write it to entry 0 sign-extended, set next_done and go to FINAL; FINAL SHALL return to INIT.
REQ-021 Latency from start accepted to done high SHALL be 13 cycles plus the Log2 latency.
REQ-022 start asserted while not in INIT SHALL be ignored.
REQ-023 Unused operator and memory outputs SHALL be driven 0 in every state; scratch_mem_write_en SHALL be high only in SHIFT_WR and WRITE0.

Reset
REQ-024 reset SHALL force state INIT, done=0, i=0 and all datapath registers to 0, including when asserted mid-operation.
REQ-025 After a mid-operation reset, no further memory write or log2_start SHALL occur until a new start.

Structure
REQ-026 PAST_QUA_EN base address and constants 13 and 24660 SHALL come from the shared paramList package.
REQ-027 The Log2 unit SHALL be a separate sub-module, log2, instantiated at the Dec_gain level and shared through the handshake ports; gain_update SHALL contain no arithmetic operators beyond index compare.

Verification
REQ-028 Prefill past_qua_en = {100, 200, 300, 400}, L_gbk12 = 0x00004000 -> entries {6165, 100, 200, 300}, single done pulse.
REQ-029 L_gbk12 = 0x00002000 (exp=13, frac=0) -> past_qua_en[0] = 0.
REQ-030 L_gbk12 = 0x00000001 -> L_shl saturates to 0x80000000, tmp = -32768, past_qua_en[0] = -24660 stored as 0xFFFF9FAC.
REQ-031 Log2 responder delaying log2_done by 0 and 20 cycles -> identical results, latency 13+N cycles.
REQ-032 reset asserted in LOG_WAIT, then start with 0x00004000 -> outputs 0 after reset, clean full update afterward, and no write from the aborted run.
